// File: rtl/bus_arbiter_rr_if.sv
// Bundle of request/grant/completion signals between the bus masters, the bus slave and
// the round-robin arbiter, plus read-only debug views of the arbiter FSM.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 2
);
    // Handshake: req[i] is a level held by master i until it sees grant[i]; once granted the
    // bus is owned until bus_done (a one-cycle completion pulse from the slave) releases it.
    // req is not a valid/ready pair on its own: dropping it never cancels an active grant.
    logic [NUM_MASTERS-1:0] req;
    logic                   bus_done;
    logic [NUM_MASTERS-1:0] grant;
    logic [ID_WIDTH-1:0]    grant_id;
    logic                   busy;
    logic                   timeout;
    logic [0:0]             fsm_state;
    logic [ID_WIDTH-1:0]    rr_ptr;

    modport master (
        input  req, bus_done,
        output grant, grant_id, busy, timeout, fsm_state, rr_ptr
    );

    modport slave (
        output req, bus_done,
        input  grant, grant_id, busy, timeout, fsm_state, rr_ptr
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: one owner at a time, held until bus_done.
// Optional watchdog release is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clock,
    input logic               reset,
    bus_arbiter_rr_if.master  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]             state;
    logic [ID_WIDTH-1:0]    ptr;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [ID_WIDTH-1:0]    grant_id_q;
    logic                   timeout_q;

    logic                   win_found;
    logic [ID_WIDTH-1:0]    win_id;
    logic [ID_WIDTH-1:0]    scan_idx;
    logic [ID_WIDTH-1:0]    ptr_next;
    logic                   to_hit;

    // Scan from the farthest offset down so the slot nearest ptr is written last and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            scan_idx = ID_WIDTH'((int'(ptr) + i) % NUM_MASTERS);
            if (bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    assign ptr_next = (grant_id_q == ID_WIDTH'(NUM_MASTERS - 1)) ? '0
                                                                  : grant_id_q + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    assign to_hit = (state == ST_BUSY) && !bus.bus_done && (wd_cnt == CW'(TIMEOUT_CYCLES));

    // Held at zero while idle, which is equivalent to clearing on entry to BUSY.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wd_cnt <= '0;
        end else if (!bus.bus_done && !to_hit) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state      <= ST_BUSY;
                        grant_q    <= NUM_MASTERS'(1) << win_id;
                        grant_id_q <= win_id;
                    end
                end
                ST_BUSY: begin
                    // bus_done takes priority over the watchdog on the same cycle.
                    if (bus.bus_done || to_hit) begin
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        ptr       <= ptr_next;
                        timeout_q <= to_hit;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state == ST_BUSY);
    assign bus.timeout   = timeout_q;
    assign bus.fsm_state = state;
    assign bus.rr_ptr    = ptr;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: integer-level round-robin model compared every
// cycle, plus directed literal checks. Honors `define BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bus_arbiter_rr_if #(.NUM_MASTERS(N), .ID_WIDTH(IW)) bif ();

  bus_arbiter_rr #(.NUM_MASTERS(N), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: owner index (-1 = free), rotating priority start, busy-cycle count
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_to    = 1'b0;
      m_valid = 1'b1;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bif.req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (bif.bus_done || (TO_EN && m_cnt == TO)) begin
      m_to    = !bif.bus_done;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_cnt++;
      m_to = 1'b0;
    end
  end

  // compare process
  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_busy", 32'(bif.busy), 32'(m_owner >= 0));
      chk("model_grant", 32'(bif.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      if (m_owner >= 0) chk("model_grant_id", 32'(bif.grant_id), 32'(m_owner));
      chk("model_timeout", 32'(bif.timeout), 32'(m_to));
    end
  end

  // driver tasks
  task automatic step(input logic [N-1:0] r, input logic d);
    bif.req      = r;
    bif.bus_done = d;
    @(posedge clock);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g, input logic b);
    chk({name, "_grant"}, 32'(bif.grant), 32'(g));
    chk({name, "_busy"}, 32'(bif.busy), 32'(b));
  endtask

  logic [N-1:0] rr_seq [4];

  initial begin
    rr_seq[0] = 4'b0010;
    rr_seq[1] = 4'b0100;
    rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001;
    reset        = 1'b1;
    bif.req      = '0;
    bif.bus_done = 1'b0;

    // reset held with all requesting
    step(4'b1111, 1'b0);
    expect_out("rst_c1", 4'b0000, 1'b0);
    step(4'b1111, 1'b0);
    expect_out("rst_c2", 4'b0000, 1'b0);
    chk("rst_ptr", 32'(bif.rr_ptr), 32'd0);
    chk("rst_timeout", 32'(bif.timeout), 32'd0);
    reset = 1'b0;
    step(4'b1111, 1'b0);
    expect_out("first", 4'b0001, 1'b1);
    chk("first_id", 32'(bif.grant_id), 32'd0);

    // full rotation with one dead cycle between owners
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      expect_out("rr_gap", 4'b0000, 1'b0);
      step(4'b1111, 1'b0);
      expect_out("rr_next", rr_seq[k], 1'b1);
    end

    // wrap: serve master 1, then req=0011 with ptr=2 picks master 0 then master 1
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    expect_out("m1", 4'b0010, 1'b1);
    step(4'b0011, 1'b1);
    chk("ptr_after_m1", 32'(bif.rr_ptr), 32'd2);
    step(4'b0011, 1'b0);
    expect_out("wrap_m0", 4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b0);
    expect_out("wrap_m1", 4'b0010, 1'b1);

    // master 2 drops req mid-transaction; bus_done while idle ignored
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b0);
    expect_out("m2", 4'b0100, 1'b1);
    step(4'b0000, 1'b0);
    expect_out("hold_noreq", 4'b0100, 1'b1);
    step(4'b0000, 1'b0);
    expect_out("hold_noreq2", 4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    expect_out("m2_release", 4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    expect_out("done_idle", 4'b0000, 1'b0);
    chk("done_idle_ptr", 32'(bif.rr_ptr), 32'd3);
    step(4'b1111, 1'b0);
    expect_out("m3", 4'b1000, 1'b1);
    chk("m3_id", 32'(bif.grant_id), 32'd3);

    // reset while busy drops the grant and restores master 0 priority
    reset = 1'b1;
    step(4'b1111, 1'b0);
    expect_out("rst_busy", 4'b0000, 1'b0);
    chk("rst_busy_ptr", 32'(bif.rr_ptr), 32'd0);
    reset = 1'b0;
    step(4'b1111, 1'b0);
    expect_out("post_rst", 4'b0001, 1'b1);

    // master 1 owns the bus with no completion
    step(4'b0110, 1'b1);
    step(4'b0110, 1'b0);
    expect_out("stall_m1", 4'b0010, 1'b1);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      step(4'b0110, 1'b0);
      expect_out("wd_wait", 4'b0010, 1'b1);
      chk("wd_wait_to", 32'(bif.timeout), 32'd0);
    end
    step(4'b0110, 1'b0);
    expect_out("wd_release", 4'b0000, 1'b0);
    chk("wd_pulse", 32'(bif.timeout), 32'd1);
    step(4'b0110, 1'b0);
    expect_out("wd_next_m2", 4'b0100, 1'b1);
    chk("wd_pulse_end", 32'(bif.timeout), 32'd0);
`else
    for (int k = 0; k < 40; k++) step(4'b0110, 1'b0);
    expect_out("stall_held", 4'b0010, 1'b1);
    chk("stall_no_to", 32'(bif.timeout), 32'd0);
`endif
    step(4'b0000, 1'b1);
    expect_out("final_release", 4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // run-length bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "bench time limit reached");
  end
endmodule
